uart_rx: RTL and testbench

- UART receiver; the receive-side counterpart of the team's uart_tx_rev2 transmitter.
- Recovers 8N1 frames (1 start, DATA_BITS data LSB-first, 1 stop) from the asynchronous serial line `rx`.
- Uses an externally generated oversampling tick at OVERSAMPLE x baud; tick generation is outside this block.
- Delivers each received byte as a one-cycle valid pulse, with framing-error reporting; sits between the pad and the byte-consumer logic.

---
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by an external OVERSAMPLE x baud sample tick.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 sample_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK_WAIT
  } state_e;

  state_e state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic ferr_q, ferr_d;
  logic meta_q, rx_s_q;
  logic wrap;
`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic pflag_q, pflag_d;
`endif

  assign wrap = (tick_q == T_LAST);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = 1'b0;
    pflag_d = pflag_q;
`endif
    if (sample_tick) begin
      tick_d = tick_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          tick_d = '0;
          if (!rx_s_q) state_d = START;
        end
        START: begin
          if (tick_q == T_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end
        end
        DATA: begin
          if (wrap) begin
            tick_d  = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (wrap) begin
            tick_d  = '0;
            pflag_d = ^{rx_s_q, shift_q};
            state_d = STOP;
          end
        end
`endif
        STOP: begin
          if (wrap) begin
            tick_d = '0;
            if (rx_s_q) begin
              state_d = IDLE;
`ifdef UART_RX_PARITY_EN
              perr_d  = pflag_q;
              valid_d = !pflag_q;
              if (!pflag_q) data_d = shift_q;
`else
              valid_d = 1'b1;
              data_d  = shift_q;
`endif
            end else begin
              state_d = BRK_WAIT;
              ferr_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_d  = pflag_q;
`endif
            end
          end
        end
        // Hold off re-arming while the line is held low (break).
        BRK_WAIT: begin
          tick_d = '0;
          if (rx_s_q) state_d = IDLE;
        end
        default: begin
          tick_d  = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      meta_q  <= 1'b1;
      rx_s_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pflag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      meta_q  <= rx;
      rx_s_q  <= meta_q;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pflag_q <= pflag_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames serialised at 80 clks/bit,
// expected pulses queued at send time and popped by a monitor.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       sample_tick;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .sample_tick(sample_tick),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  typedef struct {
    bit         v;
    bit         fe;
    bit         pe;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_v = 0;
  int         prev_v = 0;
  int         div = 0;

  initial forever #50 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      sample_tick = (div == 4);
      div = (div == 4) ? 0 : div + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Reference model: frame outcome follows directly from stop/parity bits.
  task automatic expect_frame(input logic [7:0] d, input bit stop_ok,
                              input bit par_ok);
    ev_t e;
    e.v  = stop_ok && par_ok;
    e.fe = !stop_ok;
    e.pe = !par_ok;
    if (e.v) last_good = d;
    e.data = last_good;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst && (rx_valid || frame_err || parity_err)) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: v=%b fe=%b pe=%b, expected none",
                 rx_valid, frame_err, parity_err);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {29'd0, rx_valid, frame_err, parity_err},
              {29'd0, e.v, e.fe, e.pe});
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        if (rx_valid) begin
          check("busy_at_valid", {31'd0, rx_busy}, 32'd0);
          prev_v = last_v;
          last_v = cyc;
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (80) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                            input bit par_ok, input int hold);
    bit pok;
    pok = par_ok;
`ifndef UART_RX_PARITY_EN
    pok = 1'b1;
`endif
    expect_frame(d, stop_ok, pok);
    drive_bit(1'b0);
    check("busy_in_frame", {31'd0, rx_busy}, 32'd1);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ !pok);
`endif
    drive_bit(stop_ok);
    if (!stop_ok) begin
      repeat (hold) drive_bit(1'b0);
      check("busy_in_break", {31'd0, rx_busy}, 32'd1);
      rx = 1'b1;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_perr", {31'd0, parity_err}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);

    send_frame(8'hA5, 1'b1, 1'b1, 0);
    drive_bit(1'b1);
    wait_drain();

    send_frame(8'h3C, 1'b1, 1'b1, 0);
    send_frame(8'h7E, 1'b1, 1'b1, 0);
    wait_drain();
    check("b2b_spacing", last_v - prev_v, 32'd800);
    drive_bit(1'b1);

    rx = 1'b0;
    repeat (15) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("false_start_busy", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h55, 1'b1, 1'b1, 0);
    drive_bit(1'b1);
    wait_drain();

    send_frame(8'hC3, 1'b0, 1'b1, 20);
    repeat (3) drive_bit(1'b1);
    check("break_released_busy", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h81, 1'b1, 1'b1, 0);
    drive_bit(1'b1);
    wait_drain();

    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    check("mid_rst_data", {24'd0, rx_data}, 32'd0);
    check("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
    check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    repeat (48) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'h0F, 1'b1, 1'b1, 0);
    drive_bit(1'b1);
    wait_drain();

`ifdef UART_RX_PARITY_EN
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    drive_bit(1'b1);
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    drive_bit(1'b1);
    wait_drain();
`endif

    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      bit         sok;
      bit         pok;
      d   = 8'($urandom);
      sok = ($urandom_range(0, 5) != 0);
      pok = ($urandom_range(0, 4) != 0);
      send_frame(d, sok, pok, $urandom_range(1, 4));
      if (!sok || $urandom_range(0, 1) == 1) drive_bit(1'b1);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    drive_bit(1'b1);
    wait_drain();
    repeat (200) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
